aes_key_schedule_seq: RTL and testbench
=======================================

Name: aes_key_schedule_seq

Overview:
- Iterative, multi-key-length AES key scheduler: AES-128, AES-192 and AES-256.
- Generates one 32-bit schedule word per clock using a single shared 4-S-box SubWord unit.
- Stores the full schedule, up to 60 words, in an internal word array.
- Serves round keys to the cipher datapath through a registered indexed read port.

Parameters:
- SUPPORT_192, 1: enables the AES-192 mode; when 0, mode 01 is rejected.
- SUPPORT_256, 1: enables the AES-256 mode; when 0, mode 10 is rejected.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request expansion; sampled only in IDLE.
- keyMode, input, 2: key length select. 00 = 128 (Nk=4, Nr=10); 01 = 192 (Nk=6, Nr=12); 10 = 256 (Nk=8, Nr=14); 11 = illegal.
- keyIn, input, 256: cipher key, MSB-aligned.
  - 128-bit key in keyIn[255:128].
  - 192-bit key in keyIn[255:64].
  - Unused LSBs are ignored.
- busy, output, 1: expansion in progress.
- done, output, 1: one-cycle pulse when the schedule is complete.
- keysValid, output, 1: schedule complete and readable.
- modeErr, output, 1: one-cycle pulse on a rejected start.
- numRounds, output, 4: Nr of the latched mode; 0 until the first accepted start.
- rkIdx, input, 4: round key index to read.
- roundKey, output, 128: round key rkIdx as {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered.

Behaviour:
- Reset: state = IDLE.
  - busy, done, keysValid, modeErr, numRounds and roundKey all reset to 0.
  - Rcon register resets to 8'h01.
  - The word array is not cleared.
- States: IDLE, LOAD, EXPAND, FINISH.
- IDLE:
  - start with an illegal or unsupported keyMode: modeErr = 1 for the next cycle; remain in IDLE; keysValid unchanged.
  - start with a legal keyMode: latch keyIn, Nk and Nr; set numRounds = Nr; keysValid <= 0; busy <= 1; Rcon <= 01; go to LOAD.
- LOAD (1 cycle): write w[0..Nk-1] from the latched key, w[0] taken from the most significant word. Set i = Nk and the position counter j = 0 (j tracks i mod Nk). Go to EXPAND.
- EXPAND: each cycle compute and write w[i], then i++ and j = (j == Nk-1) ? 0 : j+1. Compute w[i] as follows:
  - t = w[i-1].
  - If j == 0: t = SubWord(RotWord(t)) ^ {Rcon, 24'h0}, then Rcon <= xtime(Rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - Else if Nk == 8 and j == 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - RotWord rotates left by one byte. SubWord applies the AES S-box to each byte.
  - No division or modulo hardware; counters only.
- EXPAND exits after writing w[4*Nr+3] (the 44th, 52nd or 60th word) and goes to FINISH.
- FINISH (1 cycle): done = 1; busy <= 0; keysValid <= 1; return to IDLE.
- Latency, counted from the edge that samples start to the cycle done is high: 4*(Nr+1) - Nk + 2.
  - AES-128: 42 cycles.
  - AES-192: 48 cycles.
  - AES-256: 54 cycles.
- start while busy: ignored; no error pulse.
- start in the FINISH cycle: ignored.
- start in IDLE with keysValid = 1: restarts expansion; keysValid drops the cycle after start.
- Read port: roundKey is updated on every edge to words 4*rkIdx .. 4*rkIdx+3 when keysValid = 1 and rkIdx <= numRounds; otherwise it is updated to 128'h0. Read latency is 1 cycle.
- rkIdx > numRounds (e.g. 11..15 in AES-128): roundKey = 0.
- reset mid-expansion: in the next cycle the state is IDLE and all outputs are 0; a new start is accepted immediately afterwards.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c: done exactly 42 cycles after start.
  - rkIdx 0 -> the key itself.
  - rkIdx 1 -> a0fafe1788542cb123a339392a6c7605.
  - rkIdx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rkIdx 11 -> 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: done at 48 cycles; numRounds = 12; rkIdx 12 -> e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: done at 54 cycles; rkIdx 1 -> 1f352c073b6108d72d9810a30914dff4; rkIdx 14 -> fe4890d1e6188d0b046df344706c631e.
- keyMode 11 with start: modeErr pulses for 1 cycle; busy stays 0; keysValid is unchanged. A build with SUPPORT_256 = 0 and keyMode 10 gives the same response.
- start re-asserted at cycle 10 of an AES-128 run: ignored; done still lands at cycle 42 with correct keys. Then start an AES-256 run: keysValid = 0 until done; new keys are correct.
- reset asserted at cycle 20 of an expansion: all outputs 0 next cycle. Start AES-128 immediately after: completes at 42 cycles with round key 10 correct.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock through a shared
// 4-S-box SubWord unit, with the schedule held in eight word banks behind a registered read port.
module aes_key_schedule_seq #(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   keyMode,
  input  logic [255:0] keyIn,
  output logic         busy,
  output logic         done,
  output logic         keysValid,
  output logic         modeErr,
  output logic [3:0]   numRounds,
  input  logic [3:0]   rkIdx,
  output logic [127:0] roundKey
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FINISH} stateType;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x lives at bits [2047-8x -: 8], i.e. base index {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b111};
    return SBOX_TABLE[base -: 8];
  endfunction

  stateType      state;
  logic [255:0]  keyReg;
  logic [2:0]    nkLast;      // Nk-1
  logic [5:0]    lastIdx;     // 4*Nr+3
  logic [5:0]    wIdx;
  logic [2:0]    jPos;
  logic [7:0]    rcon;
  logic [31:0]   win [8];     // win[k] = w[i-1-k]
  logic [31:0]   keyWords [8];
  logic [31:0]   loadWord [8];
  logic [31:0]   bankRd [8];
  logic [31:0]   prevWord, oldWord, sboxIn, subOut, tWord, newWord;
  logic          modeOk;

  assign prevWord = win[0];
  assign oldWord  = win[nkLast];
  assign sboxIn   = (jPos == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
  assign tWord    = (jPos == 3'd0) ? (subOut ^ {rcon, 24'h0}) :
                    (nkLast == 3'd7 && jPos == 3'd4) ? subOut : prevWord;
  assign newWord  = oldWord ^ tWord;
  assign modeOk   = (keyMode == 2'b00) || (keyMode == 2'b01 && SUPPORT_192) ||
                    (keyMode == 2'b10 && SUPPORT_256);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gSbox
      assign subOut[8*gi +: 8] = sbox(sboxIn[8*gi +: 8]);
    end

    // Word i is stored in bank i[2:0], row i[5:3]; the key words all land in row 0.
    for (gi = 0; gi < 8; gi++) begin : gBank
      logic [31:0] bankMem [8];
      assign keyWords[gi] = keyReg[255-32*gi -: 32];
      assign loadWord[gi] = keyWords[nkLast - 3'(gi)];
      assign bankRd[gi]   = bankMem[rkIdx[3:1]];
      always_ff @(posedge clk) begin
        if (state == LOAD && 3'(gi) <= nkLast)
          bankMem[0] <= keyWords[gi];
        else if (state == EXPAND && wIdx[2:0] == 3'(gi))
          bankMem[wIdx[5:3]] <= newWord;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      keysValid <= 1'b0;
      modeErr   <= 1'b0;
      numRounds <= 4'd0;
      roundKey  <= 128'h0;
      rcon      <= 8'h01;
    end else begin
      done    <= 1'b0;
      modeErr <= 1'b0;
      if (keysValid && rkIdx <= numRounds)
        roundKey <= rkIdx[0] ? {bankRd[4], bankRd[5], bankRd[6], bankRd[7]}
                             : {bankRd[0], bankRd[1], bankRd[2], bankRd[3]};
      else
        roundKey <= 128'h0;

      case (state)
        IDLE: begin
          if (start) begin
            if (modeOk) begin
              keyReg    <= keyIn;
              keysValid <= 1'b0;
              busy      <= 1'b1;
              rcon      <= 8'h01;
              state     <= LOAD;
              case (keyMode)
                2'b00:   begin nkLast <= 3'd3; numRounds <= 4'd10; lastIdx <= 6'd43; end
                2'b01:   begin nkLast <= 3'd5; numRounds <= 4'd12; lastIdx <= 6'd51; end
                default: begin nkLast <= 3'd7; numRounds <= 4'd14; lastIdx <= 6'd59; end
              endcase
            end else begin
              modeErr <= 1'b1;
            end
          end
        end
        LOAD: begin
          win   <= loadWord;
          wIdx  <= {3'b000, nkLast} + 6'd1;
          jPos  <= 3'd0;
          state <= EXPAND;
        end
        EXPAND: begin
          win[0] <= newWord;
          for (int k = 1; k < 8; k++) win[k] <= win[k-1];
          wIdx <= wIdx + 6'd1;
          jPos <= (jPos == nkLast) ? 3'd0 : jPos + 3'd1;
          if (jPos == 3'd0)
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (wIdx == lastIdx)
            state <= FINISH;
        end
        FINISH: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          keysValid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Randomized bench for aes_key_schedule_seq against a loop-based FIPS-197 model whose S-box
// is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         reset, start, start2;
  logic [1:0]   keyMode, keyMode2;
  logic [255:0] keyIn;
  logic [3:0]   rkIdx, rkIdx2;
  logic         busy, done, keysValid, modeErr;
  logic         busy2, done2, keysValid2, modeErr2;
  logic [3:0]   numRounds, numRounds2;
  logic [127:0] roundKey, roundKey2;

  int           compareCount = 0;
  int           failCount = 0;
  logic [7:0]   sboxRef [256];
  logic [31:0]  refW [64];
  int           curNr;

  always #5 clk = ~clk;

  aes_key_schedule_seq dut (
    .clk(clk), .reset(reset), .start(start), .keyMode(keyMode), .keyIn(keyIn),
    .busy(busy), .done(done), .keysValid(keysValid), .modeErr(modeErr),
    .numRounds(numRounds), .rkIdx(rkIdx), .roundKey(roundKey)
  );

  aes_key_schedule_seq #(.SUPPORT_192(1'b1), .SUPPORT_256(1'b0)) dutNo256 (
    .clk(clk), .reset(reset), .start(start2), .keyMode(keyMode2), .keyIn(keyIn),
    .busy(busy2), .done(done2), .keysValid(keysValid2), .modeErr(modeErr2),
    .numRounds(numRounds2), .rkIdx(rkIdx2), .roundKey(roundKey2)
  );

  task automatic checkValue(input string tag, input logic [127:0] observed,
                            input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
  endfunction

  task automatic buildModel(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) refW[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = refW[i-1];
      if (i % nk == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gfMul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subWord(t);
      end
      refW[i] = refW[i-nk] ^ t;
    end
    curNr = nr;
  endtask

  function automatic logic [255:0] randKey();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic readKey(input int r, output logic [127:0] value);
    rkIdx = 4'(r);
    @(posedge clk); #1;
    value = roundKey;
  endtask

  task automatic readAll();
    logic [127:0] got, expected;
    for (int r = 0; r < 16; r++) begin
      readKey(r, got);
      expected = (r <= curNr) ? {refW[4*r], refW[4*r+1], refW[4*r+2], refW[4*r+3]} : 128'h0;
      checkValue($sformatf("rk%0d", r), got, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_busy"}, busy, 0);
    checkValue({tag, "_done"}, done, 0);
    checkValue({tag, "_kv"}, keysValid, 0);
    checkValue({tag, "_modeErr"}, modeErr, 0);
    checkValue({tag, "_numRounds"}, numRounds, 0);
    checkValue({tag, "_roundKey"}, roundKey, 0);
  endtask

  // One expansion; optionally pokes start at cycle pokeAt or resets at cycle resetAt.
  task automatic runExpansion(input logic [1:0] mode, input logic [255:0] key,
                              input int pokeAt, input int resetAt);
    int nk, nr, cycles;
    bit sawValid, finished;
    nk = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 6 : 8;
    nr = nk + 6;
    keyMode = mode; keyIn = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkValue("busy_after_start", busy, 1);
    cycles = 0; sawValid = 0; finished = 0;
    while (!finished && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (done) begin
        finished = 1;
      end else begin
        if (keysValid) sawValid = 1;
        if (cycles == pokeAt) begin
          start = 1'b1; keyMode = 2'b10; keyIn = randKey();
        end
        if (cycles == resetAt) begin
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          checkAllZero("midreset");
          $display("run mode=%0d reset at cycle %0d", mode, cycles);
          return;
        end
      end
    end
    checkValue("latency", 128'(cycles), 128'(4 * (nr + 1) - nk + 2));
    checkValue("kv_low_while_busy", sawValid, 0);
    checkValue("kv_after_done", keysValid, 1);
    checkValue("busy_after_done", busy, 0);
    checkValue("numRounds", numRounds, 128'(nr));
    @(posedge clk); #1;
    checkValue("done_one_cycle", done, 0);
    buildModel(key, nk, nr);
    $display("run mode=%0d key=%h latency=%0d", mode, key, cycles);
  endtask

  initial begin
    logic [127:0] got;
    logic [1:0]   m;
    buildSbox();
    reset = 1'b1; start = 1'b0; start2 = 1'b0; keyMode = 2'b00; keyMode2 = 2'b00;
    keyIn = '0; rkIdx = 4'd0; rkIdx2 = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkAllZero("reset");

    // AES-128 known answer with junk in the unused LSBs.
    runExpansion(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_55aa55aa}, -1, -1);
    readKey(0, got);  checkValue("kat128_rk0", got, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    readKey(1, got);  checkValue("kat128_rk1", got, 128'ha0fafe1788542cb123a339392a6c7605);
    readKey(10, got); checkValue("kat128_rk10", got, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readKey(11, got); checkValue("kat128_rk11", got, 128'h0);
    readAll();

    // Illegal mode on both builds, mode 10 on the build without AES-256.
    keyMode = 2'b11; start = 1'b1; keyMode2 = 2'b10; start2 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    checkValue("modeErr_11", modeErr, 1);
    checkValue("busy_11", busy, 0);
    checkValue("kv_kept_11", keysValid, 1);
    checkValue("modeErr_no256", modeErr2, 1);
    checkValue("busy_no256", busy2, 0);
    checkValue("kv_no256", keysValid2, 0);
    @(posedge clk); #1;
    checkValue("modeErr_pulse", modeErr, 0);
    checkValue("modeErr_no256_pulse", modeErr2, 0);
    checkValue("busy_stays_idle", busy, 0);
    checkValue("numRounds_no256", numRounds2, 0);
    checkValue("done_no256", done2, 0);
    checkValue("roundKey_no256", roundKey2, 0);
    $display("illegal mode start rejected");

    runExpansion(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0123456789abcdef}, -1, -1);
    readKey(12, got); checkValue("kat192_rk12", got, 128'he98ba06f448c773c8ecc720401002202);
    readAll();

    runExpansion(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, -1, -1);
    readKey(1, got);  checkValue("kat256_rk1", got, 128'h1f352c073b6108d72d9810a30914dff4);
    readKey(14, got); checkValue("kat256_rk14", got, 128'hfe4890d1e6188d0b046df344706c631e);
    readKey(15, got); checkValue("kat256_rk15", got, 128'h0);

    // start while busy is ignored, then an AES-256 restart from keysValid = 1.
    runExpansion(2'b00, randKey(), 10, -1);
    readAll();
    runExpansion(2'b10, randKey(), -1, -1);
    readAll();

    // Reset in the middle, then an immediate AES-128 run.
    runExpansion(2'b01, randKey(), -1, 20);
    runExpansion(2'b00, randKey(), -1, -1);
    readKey(10, got);
    checkValue("after_reset_rk10", got, {refW[40], refW[41], refW[42], refW[43]});

    for (int n = 0; n < 6; n++) begin
      m = 2'($urandom_range(0, 2));
      runExpansion(m, randKey(), -1, -1);
      readAll();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
